execute_stage_pipe: RTL

//  Registered, parametrised execute stage between the decode/operand-read (stage 3) and memory (stage 4) pipeline registers.

---
 rtl/execute_stage_pipe.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage_pipe.sv
// Execute stage between the operand-read and memory pipeline registers: forwarding muxes,
// single-cycle ALU, iterative shift-add MUL and branch compare feeding one handshaked output register.
module execute_stage_pipe #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
    parameter bit              MUL_EN    = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ir3,
    input  logic [XLEN-1:0] pc3,
    input  logic [XLEN-1:0] x3,
    input  logic [XLEN-1:0] y3,
    input  logic [XLEN-1:0] md3,
    input  logic [XLEN-1:0] z4_fwd,
    input  logic [XLEN-1:0] z5_fwd,
    input  logic [1:0]      sel_op1,
    input  logic [1:0]      sel_op2,
    input  logic [1:0]      sel_md,
    input  logic [5:0]      alu_sel,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ir4,
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] z4,
    output logic [XLEN-1:0] md4,
    output logic            br_taken,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN + 1);

    // ALU function codes
    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd1;
    localparam logic [5:0] ALU_AND  = 6'd2;
    localparam logic [5:0] ALU_OR   = 6'd3;
    localparam logic [5:0] ALU_XOR  = 6'd4;
    localparam logic [5:0] ALU_SLL  = 6'd5;
    localparam logic [5:0] ALU_SRL  = 6'd6;
    localparam logic [5:0] ALU_SRA  = 6'd7;
    localparam logic [5:0] ALU_SLT  = 6'd8;
    localparam logic [5:0] ALU_SLTU = 6'd9;
    localparam logic [5:0] ALU_PASB = 6'd10;
    localparam logic [5:0] ALU_MUL  = 6'd11;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] z;
        logic [XLEN-1:0] md;
        logic            br;
    } ex_out_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplr_q, mplr_d;
    logic [XLEN-1:0] mir_q, mir_d;
    logic [XLEN-1:0] mpc_q, mpc_d;
    logic [XLEN-1:0] mmd_q, mmd_d;
    ex_out_t         out_q, out_d;
    logic            out_valid_q, out_valid_d;

    logic [XLEN-1:0] op1, op2, md_sel, alu_res, acc_step, mul_final;
    logic            is_mul, is_branch, br_dec, slot_free, accept;

    always_comb begin
        op1 = z4_fwd;
        case (sel_op1)
            2'd0:    op1 = x3;
            2'd1:    op1 = z5_fwd;
            default: op1 = z4_fwd;
        endcase
        op2 = z4_fwd;
        case (sel_op2)
            2'd0:    op2 = y3;
            2'd1:    op2 = z5_fwd;
            default: op2 = z4_fwd;
        endcase
        md_sel = z4_fwd;
        case (sel_md)
            2'd0:    md_sel = md3;
            2'd1:    md_sel = z5_fwd;
            default: md_sel = z4_fwd;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_sel)
            ALU_ADD:  alu_res = op1 + op2;
            ALU_SUB:  alu_res = op1 - op2;
            ALU_AND:  alu_res = op1 & op2;
            ALU_OR:   alu_res = op1 | op2;
            ALU_XOR:  alu_res = op1 ^ op2;
            ALU_SLL:  alu_res = op1 << op2[SHW-1:0];
            ALU_SRL:  alu_res = op1 >> op2[SHW-1:0];
            ALU_SRA:  alu_res = $signed(op1) >>> op2[SHW-1:0];
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            ALU_PASB: alu_res = op2;
            ALU_MUL:  alu_res = op1 * op2;
            default:  alu_res = '0;
        endcase
    end

    // Branches compare the forwarded operands directly, independent of alu_sel.
    always_comb begin
        is_branch = (ir3[6:0] == 7'b1100011);
        br_dec    = 1'b0;
        if (is_branch) begin
            case (ir3[14:12])
                3'b000:  br_dec = (op1 == op2);
                3'b001:  br_dec = (op1 != op2);
                3'b100:  br_dec = ($signed(op1) <  $signed(op2));
                3'b101:  br_dec = ($signed(op1) >= $signed(op2));
                3'b110:  br_dec = (op1 <  op2);
                3'b111:  br_dec = (op1 >= op2);
                default: br_dec = 1'b0;
            endcase
        end
    end

    assign is_mul    = MUL_EN && (ir3[6:0] == 7'b0110011) && (ir3[31:25] == 7'b0000001)
                       && (ir3[14:12] == 3'b000);
    assign busy      = (state_q == S_MUL);
    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = !busy && slot_free;
    assign accept    = in_valid && in_ready && !flush;
    assign acc_step  = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    // Once cnt reaches XLEN the product is complete and only waits for the output slot.
    assign mul_final = (cnt_q == CW'(XLEN)) ? acc_q : acc_step;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        mir_d       = mir_q;
        mpc_d       = mpc_q;
        mmd_d       = mmd_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_d.ir    = NOP_INSTR;
            out_d.br    = 1'b0;
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
                out_d.ir    = NOP_INSTR;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_d = S_MUL;
                            cnt_d   = '0;
                            acc_d   = '0;
                            mcand_d = op1;
                            mplr_d  = op2;
                            mir_d   = ir3;
                            mpc_d   = pc3;
                            mmd_d   = md_sel;
                        end else begin
                            out_d.ir    = ir3;
                            out_d.pc    = pc3;
                            out_d.z     = alu_res;
                            out_d.md    = md_sel;
                            out_d.br    = br_dec;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q != CW'(XLEN)) begin
                        acc_d   = acc_step;
                        mcand_d = mcand_q << 1;
                        mplr_d  = mplr_q >> 1;
                        cnt_d   = cnt_q + CW'(1);
                    end
                    if ((cnt_q >= CW'(XLEN - 1)) && slot_free) begin
                        out_d.ir    = mir_q;
                        out_d.pc    = mpc_q;
                        out_d.z     = mul_final;
                        out_d.md    = mmd_q;
                        out_d.br    = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            mir_q       <= NOP_INSTR;
            mpc_q       <= '0;
            mmd_q       <= '0;
            out_q.ir    <= NOP_INSTR;
            out_q.pc    <= '0;
            out_q.z     <= '0;
            out_q.md    <= '0;
            out_q.br    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            mir_q       <= mir_d;
            mpc_q       <= mpc_d;
            mmd_q       <= mmd_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ir4       = out_q.ir;
    assign pc4       = out_q.pc;
    assign z4        = out_q.z;
    assign md4       = out_q.md;
    assign br_taken  = out_q.br;

endmodule
